set_bank: RTL and testbench
===========================

Name: set_bank

Overview:
- Parametrised successor to the CPLD slow-device settings register.
- Holds NDEV per-device "slow" enables and a TOW-bit slow timeout. Both are written by the address-encoded settings write cycle.
- Adds edge-qualified writes: exactly one commit per bus cycle.
- Adds a slow-hold timer. It keeps SlowActive asserted for SlowTimeout×PRESCALE clocks after any access to a device marked slow. The bus/clock-gating logic consumes this.

Parameters:
- NDEV, 7, number of per-device slow enable bits. Bit i is written from A[i+1].
- TOW, 4, timeout field width. Written from A[NDEV+TOW:NDEV+1].
- PRESCALE, 16, CLK cycles per timeout tick. Must be ≥1; 1 means no prescaling.
- SLOW_RST, 7'h36, reset value of Slow[NDEV-1:0]. Default bits 6..0 = IACK, VIA, IWM, SCC, SCSI, Snd, ClockGate = 0,1,1,0,1,1,0.
- TO_RST, 4'hF, reset value of SlowTimeout.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- POR  in  1  synchronous active-high reset.
- BACT  in  1  bus cycle active.
- A  in  NDEV+TOW (indexed [NDEV+TOW:1])  CPU address; carries the write data during a settings write.
- SetCSWR  in  1  settings-register write select.
- DevAcc  in  NDEV  per-device access decode, valid while BACT.
- Slow  out  NDEV  current per-device slow enables.
- SlowTimeout  out  TOW  current timeout setting.
- SlowActive  out  1  slow-hold window active.
- WrAck  out  1  one-cycle pulse on each commit.

Behaviour:
- Reset (POR=1 at an edge): Slow=SLOW_RST, SlowTimeout=TO_RST, SlowActive=0, WrAck=0. Hold counter, prescaler and all pipeline/edge registers clear. POR overrides every other event in that cycle.
- Write pipeline:
  - Edge k: sample wr_s <= BACT&&SetCSWR and a_s <= A.
  - Commit when wr_s=1 and wr_s_prev=0, i.e. a rising edge of the registered strobe.
  - Commit at edge k+1: Slow <= a_s[NDEV:1], SlowTimeout <= a_s[NDEV+TOW:NDEV+1], WrAck=1 for exactly that cycle.
  - New values are visible 2 edges after the strobe is first sampled.
  - Strobe held across many cycles: one commit only. A must be stable at the first sampled cycle; later changes are ignored.
  - Strobe deasserted then reasserted: a second commit.
- Access detect:
  - trig = rising edge of (BACT && |(DevAcc & Slow)), registered once (1-cycle latency).
  - If a commit and a trigger occur at the same edge, the trigger uses the pre-commit Slow value.
- Hold timer states:
  - IDLE: cnt=0, SlowActive=0.
    - On trig with SlowTimeout≠0: load cnt=SlowTimeout, prescaler=PRESCALE-1, go to HOLD.
    - On trig with SlowTimeout=0: stay IDLE (no hold).
  - HOLD: SlowActive=1.
    - Prescaler counts down each clock. At 0 it reloads and cnt decrements.
    - When cnt reaches 0, go to IDLE; SlowActive deasserts on that same edge.
    - Total SlowActive width = SlowTimeout×PRESCALE cycles.
    - Retrigger in HOLD: reload cnt and prescaler from the current SlowTimeout; stays HOLD.
    - A commit during HOLD does not alter the running count; it affects only the next load.
- SlowActive is registered, with no combinational path from inputs.
- Widths: cnt is TOW bits; prescaler is $clog2(PRESCALE) bits, minimum 1. No wraparound: cnt never decrements below 0.

Decomposition:
- Package set_pkg:
  - Bit-index localparams (SLOW_CLKGATE=0, SLOW_SND=1, SLOW_SCSI=2, SLOW_SCC=3, SLOW_IWM=4, SLOW_VIA=5, SLOW_IACK=6).
  - Default SLOW_RST and TO_RST.
  - Hold-timer state enum {IDLE, HOLD}.
- One sub-module, slow_hold_timer: trigger, load value, prescaler, counter, SlowActive.
- set_bank keeps the write pipeline, settings registers and access edge detect.

Test Plan:
- Reset: POR=1 for 2 cycles -> Slow=7'h36, SlowTimeout=4'hF, SlowActive=0, WrAck=0.
- Single write: BACT=SetCSWR=1 for 1 cycle with A[11:1]=11'h2A5 -> two edges later Slow=7'h25, SlowTimeout=4'h5, WrAck pulses 1 cycle.
- Held strobe: BACT=SetCSWR=1 for 6 cycles, A changed to 11'h7FF at cycle 3 -> single WrAck; values taken from first-cycle A only.
- Hold window: SlowTimeout=3, PRESCALE=16, Slow[SCSI]=1, BACT rises with DevAcc[2]=1 -> SlowActive high exactly 48 cycles, starting 1 cycle after the edge. An access to a non-slow device gives no assertion.
- Retrigger/zero: retrigger at cycle 20 of a 48-cycle window -> window extends to 20+1+48. With SlowTimeout=0 an access never raises SlowActive.
- Simultaneous/reset: a commit clearing Slow[2] on the same edge as the DevAcc[2] trigger -> hold still starts. POR asserted mid-HOLD -> SlowActive=0 next edge, settings return to reset values.

Source files
------------

// File: rtl/set_pkg.sv
// Shared definitions for the slow-device settings bank: device bit positions,
// reset defaults and the hold-timer state encoding.
package set_pkg;

    localparam int unsigned SLOW_CLKGATE = 0;
    localparam int unsigned SLOW_SND     = 1;
    localparam int unsigned SLOW_SCSI    = 2;
    localparam int unsigned SLOW_SCC     = 3;
    localparam int unsigned SLOW_IWM     = 4;
    localparam int unsigned SLOW_VIA     = 5;
    localparam int unsigned SLOW_IACK    = 6;

    // IACK..ClockGate = 0,1,1,0,1,1,0
    localparam logic [6:0] SLOW_RST_DEF = 7'h36;
    localparam logic [3:0] TO_RST_DEF   = 4'hF;

    typedef enum logic {
        IDLE,
        HOLD
    } hold_state_t;

endpackage

// File: rtl/slow_hold_timer.sv
// Keeps o_active high for i_load x PRESCALE clocks after each trigger;
// a trigger while holding restarts the window from the current load value.
module slow_hold_timer
    import set_pkg::*;
#(
    parameter int unsigned TOW      = 4,
    parameter int unsigned PRESCALE = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_trig,
    input  logic [TOW-1:0] i_load,
    output logic           o_active
);

    localparam int unsigned    PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_MAX = PW'(PRESCALE - 1);

    hold_state_t    r_state;
    logic [TOW-1:0] r_cnt;
    logic [PW-1:0]  r_pre;
    logic           r_active;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_pre    <= '0;
            r_active <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_trig && (i_load != '0)) begin
                        r_cnt    <= i_load;
                        r_pre    <= PRE_MAX;
                        r_active <= 1'b1;
                        r_state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (i_trig) begin
                        // A zero timeout on retrigger ends the window rather than holding at 0.
                        if (i_load != '0) begin
                            r_cnt <= i_load;
                            r_pre <= PRE_MAX;
                        end else begin
                            r_cnt    <= '0;
                            r_pre    <= '0;
                            r_active <= 1'b0;
                            r_state  <= IDLE;
                        end
                    end else if (r_pre == '0) begin
                        r_pre <= PRE_MAX;
                        if (r_cnt <= TOW'(1)) begin
                            r_cnt    <= '0;
                            r_active <= 1'b0;
                            r_state  <= IDLE;
                        end else begin
                            r_cnt <= r_cnt - TOW'(1);
                        end
                    end else begin
                        r_pre <= r_pre - PW'(1);
                    end
                end
                default: begin
                    r_cnt    <= '0;
                    r_pre    <= '0;
                    r_active <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign o_active = r_active;

endmodule

// File: rtl/set_bank.sv
// Slow-device settings register: edge-qualified address-encoded writes,
// slow-access detection and the slow-hold window.
module set_bank
    import set_pkg::*;
#(
    parameter int unsigned       NDEV     = 7,
    parameter int unsigned       TOW      = 4,
    parameter int unsigned       PRESCALE = 16,
    parameter logic [NDEV-1:0]   SLOW_RST = NDEV'(SLOW_RST_DEF),
    parameter logic [TOW-1:0]    TO_RST   = TOW'(TO_RST_DEF)
) (
    input  logic                CLK,
    input  logic                POR,
    input  logic                BACT,
    input  logic [NDEV+TOW:1]   A,
    input  logic                SetCSWR,
    input  logic [NDEV-1:0]     DevAcc,
    output logic [NDEV-1:0]     Slow,
    output logic [TOW-1:0]      SlowTimeout,
    output logic                SlowActive,
    output logic                WrAck
);

    logic                r_wr_s;
    logic                r_wr_s_prev;
    logic [NDEV+TOW:1]   r_a_s;
    logic [NDEV-1:0]     r_slow;
    logic [TOW-1:0]      r_to;
    logic                r_wrack;
    logic                r_acc_d;
    logic                r_trig;
    logic                w_commit;
    logic                w_acc;

    assign w_commit = r_wr_s & ~r_wr_s_prev;
    // Uses the registered enables, so a same-edge commit cannot mask the trigger.
    assign w_acc    = BACT & (|(DevAcc & r_slow));

    always_ff @(posedge CLK) begin
        if (POR) begin
            r_wr_s      <= 1'b0;
            r_wr_s_prev <= 1'b0;
            r_a_s       <= '0;
            r_slow      <= SLOW_RST;
            r_to        <= TO_RST;
            r_wrack     <= 1'b0;
            r_acc_d     <= 1'b0;
            r_trig      <= 1'b0;
        end else begin
            r_wr_s      <= BACT & SetCSWR;
            r_wr_s_prev <= r_wr_s;
            r_a_s       <= A;
            r_wrack     <= w_commit;
            if (w_commit) begin
                r_slow <= r_a_s[NDEV:1];
                r_to   <= r_a_s[NDEV+TOW:NDEV+1];
            end
            r_acc_d <= w_acc;
            r_trig  <= w_acc & ~r_acc_d;
        end
    end

    slow_hold_timer #(
        .TOW      (TOW),
        .PRESCALE (PRESCALE)
    ) u_hold (
        .i_clk    (CLK),
        .i_rst    (POR),
        .i_trig   (r_trig),
        .i_load   (r_to),
        .o_active (SlowActive)
    );

    assign Slow        = r_slow;
    assign SlowTimeout = r_to;
    assign WrAck       = r_wrack;

endmodule

// File: tb/tb_set_bank.sv
// Directed bench for set_bank with default parameters (NDEV=7, TOW=4, PRESCALE=16).
module tb_set_bank;
    import set_pkg::*;

    logic        CLK = 1'b0;
    logic        POR = 1'b1;
    logic        BACT = 1'b0;
    logic [11:1] A = '0;
    logic        SetCSWR = 1'b0;
    logic [6:0]  DevAcc = '0;
    logic [6:0]  Slow;
    logic [3:0]  SlowTimeout;
    logic        SlowActive;
    logic        WrAck;

    int total = 0;
    int bad   = 0;

    set_bank #(
        .NDEV     (7),
        .TOW      (4),
        .PRESCALE (16)
    ) dut (
        .CLK         (CLK),
        .POR         (POR),
        .BACT        (BACT),
        .A           (A),
        .SetCSWR     (SetCSWR),
        .DevAcc      (DevAcc),
        .Slow        (Slow),
        .SlowTimeout (SlowTimeout),
        .SlowActive  (SlowActive),
        .WrAck       (WrAck)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_cfg(input logic [11:1] val);
        BACT = 1'b1; SetCSWR = 1'b1; A = val;
        step();
        BACT = 1'b0; SetCSWR = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_reset();
        POR = 1'b1;
        step(); step();
        total++; if (Slow !== 7'h36) begin bad++; $display("FAIL reset_slow got=%h exp=36", Slow); end
        total++; if (SlowTimeout !== 4'hF) begin bad++; $display("FAIL reset_to got=%h exp=f", SlowTimeout); end
        total++; if (SlowActive !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", SlowActive); end
        total++; if (WrAck !== 1'b0) begin bad++; $display("FAIL reset_wrack got=%b exp=0", WrAck); end
        POR = 1'b0;
        step();
    endtask

    task automatic test_single_write();
        BACT = 1'b1; SetCSWR = 1'b1; A = 11'h2A5;
        step();
        BACT = 1'b0; SetCSWR = 1'b0; A = '0;
        total++; if (Slow !== 7'h36 || WrAck !== 1'b0) begin
            bad++; $display("FAIL single_early got slow=%h ack=%b exp slow=36 ack=0", Slow, WrAck);
        end
        step();
        total++; if (Slow !== 7'h25) begin bad++; $display("FAIL single_slow got=%h exp=25", Slow); end
        total++; if (SlowTimeout !== 4'h5) begin bad++; $display("FAIL single_to got=%h exp=5", SlowTimeout); end
        total++; if (WrAck !== 1'b1) begin bad++; $display("FAIL single_ack got=%b exp=1", WrAck); end
        step();
        total++; if (WrAck !== 1'b0) begin bad++; $display("FAIL single_ack_end got=%b exp=0", WrAck); end
        step();
    endtask

    task automatic test_held_strobe();
        int acks = 0;
        BACT = 1'b1; SetCSWR = 1'b1; A = 11'h184;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) A = 11'h7FF;
            if (i == 6) begin BACT = 1'b0; SetCSWR = 1'b0; A = '0; end
            step();
            if (WrAck === 1'b1) acks++;
        end
        total++; if (acks !== 1) begin bad++; $display("FAIL held_acks got=%0d exp=1", acks); end
        total++; if (Slow !== 7'h04 || SlowTimeout !== 4'h3) begin
            bad++; $display("FAIL held_vals got slow=%h to=%h exp slow=04 to=3", Slow, SlowTimeout);
        end
        // reassertion after a gap must commit again
        acks = 0;
        BACT = 1'b1; SetCSWR = 1'b1; A = 11'h184;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin BACT = 1'b0; SetCSWR = 1'b0; end
            step();
            if (WrAck === 1'b1) acks++;
        end
        total++; if (acks !== 1) begin bad++; $display("FAIL reassert_acks got=%0d exp=1", acks); end
    endtask

    task automatic test_hold_window();
        int highs = 0;
        int first = 0;
        int last  = 0;
        // access to a non-slow device (ClockGate bit clear)
        BACT = 1'b1; DevAcc = 7'h01;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin BACT = 1'b0; DevAcc = '0; end
            step();
            if (SlowActive === 1'b1) highs++;
        end
        total++; if (highs !== 0) begin bad++; $display("FAIL nonslow_highs got=%0d exp=0", highs); end
        // slow SCSI access, 48-cycle window, later retrigger
        highs = 0;
        BACT = 1'b1; DevAcc = 7'h01 << SLOW_SCSI;
        for (int e = 1; e <= 80; e++) begin
            step();
            if (e == 1) begin BACT = 1'b0; DevAcc = '0; end
            if (e == 20) begin BACT = 1'b1; DevAcc = 7'h01 << SLOW_SCSI; end
            if (e == 21) begin BACT = 1'b0; DevAcc = '0; end
            if (SlowActive === 1'b1) begin
                highs++;
                if (first == 0) first = e;
                last = e;
            end
        end
        total++; if (first !== 2) begin bad++; $display("FAIL hold_start got=%0d exp=2", first); end
        total++; if (last !== 69) begin bad++; $display("FAIL retrig_end got=%0d exp=69", last); end
        total++; if (highs !== 68) begin bad++; $display("FAIL retrig_width got=%0d exp=68", highs); end
        // plain 48-cycle window without retrigger
        highs = 0; first = 0; last = 0;
        BACT = 1'b1; DevAcc = 7'h01 << SLOW_SCSI;
        for (int e = 1; e <= 60; e++) begin
            step();
            if (e == 1) begin BACT = 1'b0; DevAcc = '0; end
            if (SlowActive === 1'b1) begin
                highs++;
                if (first == 0) first = e;
                last = e;
            end
        end
        total++; if (highs !== 48) begin bad++; $display("FAIL hold_width got=%0d exp=48", highs); end
        total++; if (last !== 49) begin bad++; $display("FAIL hold_end got=%0d exp=49", last); end
    endtask

    task automatic test_zero_timeout();
        int highs = 0;
        write_cfg(11'h004);
        total++; if (SlowTimeout !== 4'h0 || Slow !== 7'h04) begin
            bad++; $display("FAIL zero_cfg got slow=%h to=%h exp slow=04 to=0", Slow, SlowTimeout);
        end
        BACT = 1'b1; DevAcc = 7'h04;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin BACT = 1'b0; DevAcc = '0; end
            step();
            if (SlowActive === 1'b1) highs++;
        end
        total++; if (highs !== 0) begin bad++; $display("FAIL zero_highs got=%0d exp=0", highs); end
    endtask

    task automatic test_back_to_back();
        write_cfg(11'h184);
        // commit Slow=0,TO=3 on the same edge the SCSI access is detected
        BACT = 1'b1; SetCSWR = 1'b1; A = 11'h180;
        step();
        SetCSWR = 1'b0; DevAcc = 7'h04;
        step();
        total++; if (Slow !== 7'h00 || WrAck !== 1'b1) begin
            bad++; $display("FAIL simul_commit got slow=%h ack=%b exp slow=00 ack=1", Slow, WrAck);
        end
        BACT = 1'b0; DevAcc = '0;
        step();
        total++; if (SlowActive !== 1'b1) begin bad++; $display("FAIL simul_hold got=%b exp=1", SlowActive); end
        for (int i = 0; i < 10; i++) step();
        total++; if (SlowActive !== 1'b1) begin bad++; $display("FAIL mid_hold got=%b exp=1", SlowActive); end
        POR = 1'b1;
        step();
        total++; if (SlowActive !== 1'b0) begin bad++; $display("FAIL por_active got=%b exp=0", SlowActive); end
        total++; if (Slow !== 7'h36 || SlowTimeout !== 4'hF || WrAck !== 1'b0) begin
            bad++; $display("FAIL por_settings got slow=%h to=%h ack=%b exp slow=36 to=f ack=0", Slow, SlowTimeout, WrAck);
        end
        POR = 1'b0;
        step();
        total++; if (SlowActive !== 1'b0) begin bad++; $display("FAIL post_por got=%b exp=0", SlowActive); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_held_strobe();
        test_hold_window();
        test_zero_timeout();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
